// File: rtl/pipelined_adder_seg.sv
// Pipelined two's-complement add/subtract unit.
// The WIDTH-bit carry chain is cut into SEG segments; stage k resolves
// segment k using the carry registered by stage k-1. Upper operand segments
// ride along in skew registers that shrink by one segment per stage, and
// finished low result segments accumulate in de-skew registers that grow by
// one segment per stage, so all sum bits leave the last stage aligned.
// One global enable stalls every stage at once when the output is blocked.
module pipelined_adder_seg #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SL = WIDTH / SEG;

  if (SEG < 1 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_bad_param
    $error("pipelined_adder_seg: WIDTH must be a positive multiple of SEG");
  end

  // Subtraction is a + ~b + 1: invert B and force the initial carry.
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             en;

  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < SEG; k++) begin : g_stg
    localparam int RW = (k + 1) * SL;       // result bits resolved so far
    logic [SL-1:0] sa, sb;                  // this stage's operand segment
    logic          ci, vi;                  // incoming carry / valid
    logic [SL:0]   t;                       // segment sum with carry out
    logic [RW-1:0] res_n;
    logic          vld_q;
    logic [RW-1:0] res_q;
    logic          c_q;

    if (k == 0) begin : g_first
      assign sa    = a[SL-1:0];
      assign sb    = b_eff[SL-1:0];
      assign ci    = c0;
      assign vi    = in_valid;
      assign res_n = t[SL-1:0];
    end else begin : g_next
      assign sa    = g_stg[k-1].g_sk.ua_q[SL-1:0];
      assign sb    = g_stg[k-1].g_sk.ub_q[SL-1:0];
      assign ci    = g_stg[k-1].c_q;
      assign vi    = g_stg[k-1].vld_q;
      assign res_n = {t[SL-1:0], g_stg[k-1].res_q};
    end

    assign t = {1'b0, sa} + {1'b0, sb} + {{SL{1'b0}}, ci};

    // Stage register: valid always shifts with en; data only loads on a real beat
    // so bubbles never disturb the last result seen on the outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        res_q <= '0;
        c_q   <= 1'b0;
      end else if (en) begin
        vld_q <= vi;
        if (vi) begin
          res_q <= res_n;
          c_q   <= t[SL];
        end
      end
    end

    if (k < SEG - 1) begin : g_sk
      localparam int UW = WIDTH - RW;       // operand bits not yet added
      logic [UW-1:0] ua_n, ub_n, ua_q, ub_q;

      if (k == 0) begin : g_src0
        assign ua_n = a[WIDTH-1:SL];
        assign ub_n = b_eff[WIDTH-1:SL];
      end else begin : g_srcn
        assign ua_n = g_stg[k-1].g_sk.ua_q[UW+SL-1:SL];
        assign ub_n = g_stg[k-1].g_sk.ub_q[UW+SL-1:SL];
      end

      // Skew register: carries the untouched upper segments to later stages.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ua_q <= '0;
          ub_q <= '0;
        end else if (en && vi) begin
          ua_q <= ua_n;
          ub_q <= ub_n;
        end
      end
    end

    if (k == SEG - 1) begin : g_last
      logic ovf_q;
      // Overflow flag: the top segment holds both operand MSBs and the sum MSB.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          ovf_q <= 1'b0;
        else if (en && vi)
          ovf_q <= (sa[SL-1] == sb[SL-1]) && (t[SL-1] != sa[SL-1]);
      end
    end
  end

  assign out_valid = g_stg[SEG-1].vld_q;
  assign sum       = g_stg[SEG-1].res_q;
  assign cout      = g_stg[SEG-1].c_q;
  assign ovf       = g_stg[SEG-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder_seg.sv
// Scoreboard bench for pipelined_adder_seg: a 16/4 instance under
// backpressure, plus 32/1 and 32/8 instances fed the same accepted beats
// with 32-bit operands and a permanently ready sink.
module tb_pipelined_adder_seg;
  localparam int S16 = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cin, sub;
  logic [15:0] a, b;
  logic [31:0] a32, b32;

  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;
  logic        iv32;
  logic        rdy1, ov1, c1, o1, rdy8, ov8, c8, o8;
  logic [31:0] s1, s8;

  assign iv32 = in_valid & in_ready;

  pipelined_adder_seg #(.WIDTH(16), .SEG(4)) u_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  pipelined_adder_seg #(.WIDTH(32), .SEG(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy1),
    .a(a32), .b(b32), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(1'b1),
    .sum(s1), .cout(c1), .ovf(o1));

  pipelined_adder_seg #(.WIDTH(32), .SEG(8)) u_l8 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy8),
    .a(a32), .b(b32), .cin(cin), .sub(sub),
    .out_valid(ov8), .out_ready(1'b1),
    .sum(s8), .cout(c8), .ovf(o8));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  exp_t q16[$], q1[$], q8[$];
  bit   exp_v[int];
  int   cyc = 0;
  bit   exact = 1'b0;
  int   tests = 0, fails = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: integer arithmetic on the operand values, no bit-level carry chain.
  function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic su, input int acc);
    exp_t   e;
    longint m, ux, uy, sx, sy, r, st;
    m  = longint'(1) << w;
    ux = {32'b0, x} & (m - 1);
    uy = {32'b0, y} & (m - 1);
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    r  = su ? ux - uy : ux + uy + longint'(ci);
    st = su ? sx - sy : sx + sy + longint'(ci);
    e.s   = 32'(r & (m - 1));
    e.c   = su ? (ux >= uy) : (r >= m);
    e.o   = (st >= m / 2) || (st < -(m / 2));
    e.acc = acc;
    return e;
  endfunction

  // Scoreboard push on every accepting edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) begin
      q16.push_back(model(16, {16'b0, a}, {16'b0, b}, cin, sub, cyc));
      q1.push_back(model(32, a32, b32, cin, sub, cyc));
      q8.push_back(model(32, a32, b32, cin, sub, cyc));
      exp_v[cyc + S16] = 1'b1;
    end
  end

  // Monitor for the 16/4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (exact)
        chk(out_valid == (exp_v.exists(cyc) != 0), "m_valid_timing", 64'(out_valid), 64'(exp_v.exists(cyc) != 0));
      if (out_valid) begin
        if (q16.size() == 0) begin
          chk(1'b0, "m_spurious_output", {47'b0, ovf, cout, sum}, 64'd0);
        end else if (out_ready) begin
          e = q16.pop_front();
          chk({ovf, cout, sum} == {e.o, e.c, e.s[15:0]}, "m_result",
              {47'b0, ovf, cout, sum}, {47'b0, e.o, e.c, e.s[15:0]});
          if (exact) chk(cyc == e.acc + S16, "m_latency", 64'(cyc - e.acc), 64'(S16));
          else       chk(cyc >= e.acc + S16, "m_latency_min", 64'(cyc - e.acc), 64'(S16));
        end else begin
          e = q16[0];
          chk({ovf, cout, sum} == {e.o, e.c, e.s[15:0]}, "m_hold",
              {47'b0, ovf, cout, sum}, {47'b0, e.o, e.c, e.s[15:0]});
          chk(in_ready == 1'b0, "m_in_ready_stall", 64'(in_ready), 64'd0);
        end
      end
    end
  end

  // Monitor for the 32/1 and 32/8 instances (never stalled: exact latency).
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ov1) begin
        if (q1.size() == 0) chk(1'b0, "l1_spurious_output", {31'b0, o1, c1, s1}, 64'd0);
        else begin
          e = q1.pop_front();
          chk({o1, c1, s1} == {e.o, e.c, e.s}, "l1_result", {30'b0, o1, c1, s1}, {30'b0, e.o, e.c, e.s});
          chk(cyc == e.acc + 1, "l1_latency", 64'(cyc - e.acc), 64'd1);
        end
      end
      if (ov8) begin
        if (q8.size() == 0) chk(1'b0, "l8_spurious_output", {31'b0, o8, c8, s8}, 64'd0);
        else begin
          e = q8.pop_front();
          chk({o8, c8, s8} == {e.o, e.c, e.s}, "l8_result", {30'b0, o8, c8, s8}, {30'b0, e.o, e.c, e.s});
          chk(cyc == e.acc + 8, "l8_latency", 64'(cyc - e.acc), 64'd8);
        end
      end
    end
  end

  // Present one beat and hold it until the 16/4 instance accepts it.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic su);
    bit ok;
    int n;
    a = x[15:0]; b = y[15:0]; a32 = x; b32 = y; cin = ci; sub = su;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk(1'b0, "accept_timeout", 64'(n), 64'd200);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit done;
    in_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      if (q16.size() == 0 && q1.size() == 0 && q8.size() == 0) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!done) chk(1'b0, "drain_timeout", 64'(q16.size() + q1.size() + q8.size()), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  bit rand_on;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; a32 = '0; b32 = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({out_valid, cout, ovf, sum} == 19'd0, "reset_outputs_m", {45'b0, out_valid, cout, ovf, sum}, 64'd0);
    chk({ov8, c8, o8, s8} == 35'd0, "reset_outputs_l8", {29'b0, ov8, c8, o8, s8}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk({in_ready, rdy1, rdy8} == 3'b111, "in_ready_after_reset", 64'({in_ready, rdy1, rdy8}), 64'd7);

    // Directed values, exact latency tracking.
    exact = 1'b1;
    send(32'h1234, 32'h1111, 1'b0, 1'b0); idle();
    send(32'hFFFF, 32'h0001, 1'b0, 1'b0);
    send(32'h7FFF, 32'h0000, 1'b1, 1'b0); idle();
    send(32'h0005, 32'h0007, 1'b1, 1'b1);
    send(32'h8000, 32'h0001, 1'b1, 1'b1); idle();
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    drain();

    // Backpressure: 8 back-to-back beats, sink blocked for 4 cycles.
    exact = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'(i), 32'(i), 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();

    // Bubble pattern 1,0,1,1.
    exact = 1'b1;
    send(32'h0101, 32'h0202, 1'b0, 1'b0); idle();
    send(32'h0303, 32'h0404, 1'b1, 1'b0);
    send(32'h0505, 32'h0606, 1'b0, 1'b1);
    drain();

    // Randomized traffic with random backpressure.
    exact = 1'b0;
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(9) < 3) idle();
          send($urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #2 out_ready = ($urandom_range(9) < 7);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight.
    exact = 1'b1;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    q16.delete(); q1.delete(); q8.delete(); exp_v.delete();
    #1;
    chk({out_valid, cout, ovf, sum} == 19'd0, "midflight_reset_m", {45'b0, out_valid, cout, ovf, sum}, 64'd0);
    chk({ov8, c8, o8, s8} == 35'd0, "midflight_reset_l8", {29'b0, ov8, c8, o8, s8}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk({out_valid, sum} == 17'd0, "post_reset_idle", {47'b0, out_valid, sum}, 64'd0);
    send(32'h0001, 32'h0001, 1'b0, 1'b0);
    drain();

    chk(q16.size() == 0, "q16_empty", 64'(q16.size()), 64'd0);
    chk(q1.size() == 0, "q1_empty", 64'(q1.size()), 64'd0);
    chk(q8.size() == 0, "q8_empty", 64'(q8.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_seg.md
Name: pipelined_adder_seg

Overview:
- Parametrised, pipelined two's-complement add/subtract unit.
- Successor to the team's fixed 16-bit combinational adder; feeds the partial-product accumulation tree of the Vedic multiplier.
- The WIDTH-bit carry chain is split into SEG segments, with one segment resolved per pipeline stage, so wide adds close timing.
- Valid/ready handshake on both sides; full backpressure; carry-out and signed-overflow flags.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, number of carry-chain segments = pipeline stages = latency in cycles; legal range 1..WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1), cin ignored.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow (operand MSBs equal after B inversion, result MSB differs).

Behaviour:
- Reset (async assert, sync release): all stage valid flags 0; out_valid=0, sum=0, cout=0, ovf=0; in-flight beats discarded. in_ready=1 from the first cycle after reset.
- Global advance enable: en = !out_valid || out_ready. in_ready = en (combinational). The whole pipeline shifts only when en=1; bubbles shift like data.
- Accept: a beat is accepted on an edge where in_valid && in_ready. in_valid while in_ready=0 is ignored; the source must hold it.
- Data movement per accepted beat:
  - At the accept edge, segment 0 is computed from a[SL-1:0] and b (inverted if sub) plus the initial carry, where SL = WIDTH/SEG. Initial carry = sub ? 1 : cin. Result and carry are registered in stage 0.
  - The upper operand segments are captured into skew registers alongside.
  - Stage k (k=1..SEG-1) adds segment k using the carry registered by stage k-1.
  - Lower result segments are delayed in de-skew registers, so all sum bits emerge aligned.
- Latency: a beat accepted at edge N drives out_valid=1 with its sum/cout/ovf after edge N+SEG-1 (SEG=1: result registered at the accept edge).
- Throughput: one beat per cycle while out_ready=1.
- Output hold: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid are held stable and every stage holds. No beat is lost or duplicated.
- Simultaneous events: when out_ready=1 and a new beat arrives in the same cycle, the output drains and the new beat enters in the same edge.
- in_valid=0 with en=1 inserts a bubble; out_valid is 0 when that bubble reaches the output.
- Result equivalence: sum = (a + b_eff + c0) mod 2^WIDTH, cout = bit WIDTH of that sum.
- ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]), where b_eff = sub ? ~b : b.
- Mode and cin are sampled at accept only; changing them mid-flight does not affect beats already in the pipeline.
- Reset mid-operation clears all beats immediately. sum/cout/ovf read 0 until new results arrive.

Test Plan:
- WIDTH=16, SEG=4: a=0x1234, b=0x1111, cin=0, sub=0, accept at edge 10 -> out_valid after edge 13 with sum=0x2345, cout=0, ovf=0.
- Carry across every segment boundary: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Subtract: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. Then sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1. cin=1 is ignored in both.
- Backpressure: stream 8 beats a=i, b=i (i=0..7) back-to-back, hold out_ready=0 for cycles 6..9 -> in_ready=0 during the stall, sums 0,2,4,…,14 in order, no loss or duplication, stable outputs while stalled.
- Bubbles: in_valid pattern 1,0,1,1 -> out_valid pattern 1,0,1,1 exactly SEG-1 edges later.
- Reset mid-flight: assert rst with 3 beats in flight -> out_valid, sum, cout, ovf go 0 immediately. After release, one beat 0x0001+0x0001 -> sum=0x0002. Repeat the first scenario with WIDTH=32, SEG=1 and WIDTH=32, SEG=8 for latency 1 and 8.
